// File: rtl/address_gen_param.sv
// ---------------------------------------------------------------------------
// address_gen_param
//
// Parametrised test-address generator for the PMBIST datapath. It produces
// linear (windowed), pseudo-random (reversible Fibonacci LFSR) and optional
// address-complement sequences. It also flags the terminal address of each
// march element.
//
// Optional feature macro: ADDR_GEN_CPL_EN
//   defined   -> complement mode (mode_in = 2'b10) is built, with a phase bit.
//   undefined -> no phase register; mode 2'b10 behaves as linear.
//
// Parameters:
//   AW        address width, 4..16
//   ADDR_MIN  lowest address of the linear/complement window
//   ADDR_MAX  highest address of the linear/complement window (>= ADDR_MIN)
//   PR_SEED   LFSR seed (0 is replaced by 1)
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   mode_in   00 linear, 01 pseudo-random, 10 complement, 11 linear
//   start_in  load first address of an up sequence
//   rev_in    load first address of a down sequence
//   hold_in   freeze address and terminal flag
//   updwn_in  0 up, 1 down
//   tas_out   registered test address
//   last_out  registered flag: tas_out is the terminal address
// ---------------------------------------------------------------------------
module address_gen_param #(
    parameter int AW       = 8,
    parameter int ADDR_MIN = 0,
    parameter int ADDR_MAX = (1 << AW) - 1,
    parameter int PR_SEED  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode_in,
    input  logic          start_in,
    input  logic          rev_in,
    input  logic          hold_in,
    input  logic          updwn_in,
    output logic [AW-1:0] tas_out,
    output logic          last_out
);

    // LFSR feedback tap mask: bit (t-1) is set for every tap t.
    function automatic logic [15:0] tap_mask(input int aw);
        logic [15:0] m;
        case (aw)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h000C;
        endcase
        return m;
    endfunction

    localparam logic [AW-1:0] ZERO_V  = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_V   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] MIN_V   = AW'(ADDR_MIN);
    localparam logic [AW-1:0] MAX_V   = AW'(ADDR_MAX);
    // Forward taps select c[t-1]. Reverse taps select c[t] for t < AW, so the
    // mask is shifted up by one and the top tap (t = AW) falls off.
    localparam logic [AW-1:0] TAPS_UP = AW'(tap_mask(AW));
    localparam logic [AW-1:0] TAPS_DN = AW'({tap_mask(AW), 1'b0});
    localparam logic [AW-1:0] SEED_V  = (AW'(PR_SEED) == ZERO_V) ? ONE_V : AW'(PR_SEED);

    // Even-parity helper used by both LFSR directions.
    function automatic logic parity(input logic [AW-1:0] v);
        return ^v;
    endfunction

    function automatic logic [AW-1:0] pr_up(input logic [AW-1:0] c);
        return {c[AW-2:0], parity(c & TAPS_UP)};
    endfunction

    // Exact inverse of pr_up: recovers the bit that was shifted out.
    function automatic logic [AW-1:0] pr_dn(input logic [AW-1:0] c);
        return {c[0] ^ parity(c & TAPS_DN), c[AW-1:1]};
    endfunction

    // One linear step inside [MIN_V, MAX_V]; out-of-window values re-enter
    // at the first address of the current direction.
    function automatic logic [AW-1:0] lin_step(input logic [AW-1:0] c, input logic dn);
        logic [AW:0] ge_min;
        logic [AW:0] le_max;
        logic [AW-1:0] r;
        // Borrow-out (top bit) is set when the comparison fails.
        ge_min = {1'b0, c} - {1'b0, MIN_V};
        le_max = {1'b0, MAX_V} - {1'b0, c};
        if (ge_min[AW] || le_max[AW]) begin
            r = dn ? MAX_V : MIN_V;
        end else if (dn) begin
            r = (c == MIN_V) ? MAX_V : (c - ONE_V);
        end else begin
            r = (c == MAX_V) ? MIN_V : (c + ONE_V);
        end
        return r;
    endfunction

    // Terminal addresses of the pseudo-random sequence, fixed at elaboration.
    localparam logic [AW-1:0] PR_PRED = pr_dn(SEED_V);
    localparam logic [AW-1:0] PR_SUCC = pr_up(SEED_V);

    logic [AW-1:0] base_r;
    logic [AW-1:0] base_nx_s;
    logic [AW-1:0] tas_nx_s;
    logic          last_nx_s;
    logic          pr_mode_s;
    logic          lin_term_s;
    logic          cpl_mode_s;
    logic          phase_nx_s;
    logic          phase_cur_s;

    assign pr_mode_s = (mode_in == 2'b01);

`ifdef ADDR_GEN_CPL_EN
    logic phase_r;
    assign cpl_mode_s  = (mode_in == 2'b10);
    assign phase_cur_s = phase_r;
`else
    assign cpl_mode_s  = 1'b0;
    assign phase_cur_s = 1'b0;
`endif

    // Next base/phase selection, then next output address and terminal flag.
    always_comb begin
        base_nx_s  = base_r;
        phase_nx_s = phase_cur_s;
        tas_nx_s   = tas_out;
        last_nx_s  = last_out;
        lin_term_s = 1'b0;
        if (start_in || rev_in) begin
            // start wins over rev when both are asserted
            if (pr_mode_s) begin
                base_nx_s = SEED_V;
            end else begin
                base_nx_s = start_in ? MIN_V : MAX_V;
            end
            phase_nx_s = 1'b0;
        end else if (hold_in) begin
            base_nx_s  = base_r;
            phase_nx_s = phase_cur_s;
        end else if (pr_mode_s) begin
            if (base_r == ZERO_V) begin
                base_nx_s = SEED_V;
            end else begin
                base_nx_s = updwn_in ? pr_dn(base_r) : pr_up(base_r);
            end
            phase_nx_s = 1'b0;
        end else if (cpl_mode_s && !phase_cur_s) begin
            // first half of a complement pair: same base, inverted address
            base_nx_s  = base_r;
            phase_nx_s = 1'b1;
        end else begin
            base_nx_s  = lin_step(base_r, updwn_in);
            phase_nx_s = 1'b0;
        end

        if (hold_in && !start_in && !rev_in) begin
            tas_nx_s  = tas_out;
            last_nx_s = last_out;
        end else begin
            tas_nx_s   = phase_nx_s ? ~base_nx_s : base_nx_s;
            lin_term_s = updwn_in ? (base_nx_s == MIN_V) : (base_nx_s == MAX_V);
            if (pr_mode_s) begin
                last_nx_s = updwn_in ? (base_nx_s == PR_SUCC) : (base_nx_s == PR_PRED);
            end else if (cpl_mode_s) begin
                last_nx_s = phase_nx_s && lin_term_s;
            end else begin
                last_nx_s = lin_term_s;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r   <= ZERO_V;
            tas_out  <= ZERO_V;
            last_out <= 1'b0;
        end else begin
            base_r   <= base_nx_s;
            tas_out  <= tas_nx_s;
            last_out <= last_nx_s;
        end
    end

`ifdef ADDR_GEN_CPL_EN
    // Complement phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= phase_nx_s;
        end
    end
`endif

endmodule

// File: tb/tb_address_gen_param.sv
module tb_address_gen_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       start, rev, hold, updwn;

    logic [3:0]  tas_lin;
    logic        last_lin;
    logic [3:0]  tas_p4;
    logic        last_p4;
    logic [7:0]  tas_p8;
    logic        last_p8;
    logic [15:0] tas_p16;
    logic        last_p16;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        int          due;
        int          which;
        logic [15:0] tas;
        logic        last;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    localparam int LIN = 0, P4 = 1, P8 = 2, P16 = 3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    address_gen_param #(.AW(4), .ADDR_MIN(2), .ADDR_MAX(5), .PR_SEED(1)) u_lin (
        .clk(clk), .rst(rst), .mode_in(mode), .start_in(start), .rev_in(rev),
        .hold_in(hold), .updwn_in(updwn), .tas_out(tas_lin), .last_out(last_lin));

    address_gen_param #(.AW(4), .PR_SEED(1)) u_p4 (
        .clk(clk), .rst(rst), .mode_in(mode), .start_in(start), .rev_in(rev),
        .hold_in(hold), .updwn_in(updwn), .tas_out(tas_p4), .last_out(last_p4));

    address_gen_param #(.AW(8)) u_p8 (
        .clk(clk), .rst(rst), .mode_in(mode), .start_in(start), .rev_in(rev),
        .hold_in(hold), .updwn_in(updwn), .tas_out(tas_p8), .last_out(last_p8));

    address_gen_param #(.AW(16), .PR_SEED(0)) u_p16 (
        .clk(clk), .rst(rst), .mode_in(mode), .start_in(start), .rev_in(rev),
        .hold_in(hold), .updwn_in(updwn), .tas_out(tas_p16), .last_out(last_p16));

    function automatic logic [15:0] get_tas(input int w);
        case (w)
            LIN:     return {12'h000, tas_lin};
            P4:      return {12'h000, tas_p4};
            P8:      return {8'h00, tas_p8};
            P16:     return tas_p16;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic get_last(input int w);
        case (w)
            LIN:     return last_lin;
            P4:      return last_p4;
            P8:      return last_p8;
            P16:     return last_p16;
            default: return 1'bx;
        endcase
    endfunction

    task automatic drive(input logic [1:0] m, input logic s, input logic r,
                         input logic h, input logic u);
        mode = m; start = s; rev = r; hold = h; updwn = u;
    endtask

    task automatic expect_v(input int w, input logic [15:0] t, input logic l, input string n);
        exp_t e;
        e.due = cyc + 1; e.which = w; e.tas = t; e.last = l; e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops every expectation due by this cycle and compares.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp = n_cmp + 1;
            if (mon_e.due != cyc || get_tas(mon_e.which) !== mon_e.tas ||
                get_last(mon_e.which) !== mon_e.last) begin
                n_bad = n_bad + 1;
                $display("FAIL %s (cyc %0d): got tas=%h last=%b, want tas=%h last=%b",
                         mon_e.name, cyc, get_tas(mon_e.which), get_last(mon_e.which),
                         mon_e.tas, mon_e.last);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [15:0] seq4 [0:15];
    logic [3:0]  b;
    logic        ph;

    initial begin
        seq4 = '{16'd1, 16'd2, 16'd4, 16'd9, 16'd3, 16'd6, 16'd13, 16'd10,
                 16'd5, 16'd11, 16'd7, 16'd15, 16'd14, 16'd12, 16'd8, 16'd1};

        // Reset state
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) expect_v(w, 16'h0000, 1'b0, "reset");
        tick();
        rst = 1'b0;

        // Zero-state escape in PR mode loads the seed (seed 0 becomes 1 on p16)
        drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_v(P4, 16'h0001, 1'b0, "p4_zero_escape");
        expect_v(P8, 16'h0001, 1'b0, "p8_zero_escape");
        expect_v(P16, 16'h0001, 1'b0, "p16_zero_escape");
        tick();

        // PR AW=4 full up cycle, last on 8
        drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_v(P4, 16'h0001, 1'b0, "p4_start");
        tick();
        for (int i = 1; i <= 15; i++) begin
            drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_v(P4, seq4[i], (seq4[i] == 16'd8), "p4_up");
            tick();
        end
        // PR AW=4 down from seed, last on 2
        drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_v(P4, 16'h0001, 1'b0, "p4_rev");
        tick();
        for (int j = 1; j <= 15; j++) begin
            drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
            expect_v(P4, seq4[15-j], (seq4[15-j] == 16'd2), "p4_down");
            tick();
        end

        // Reversibility on AW=8 and AW=16
        drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_v(P8, 16'h0001, 1'b0, "p8_start");
        expect_v(P16, 16'h0001, 1'b0, "p16_start");
        tick();
        for (int i = 1; i <= 100; i++) begin
            drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 1) begin expect_v(P8, 16'h0002, 1'b0, "p8_up1"); expect_v(P16, 16'h0002, 1'b0, "p16_up1"); end
            if (i == 2) begin expect_v(P8, 16'h0004, 1'b0, "p8_up2"); expect_v(P16, 16'h0004, 1'b0, "p16_up2"); end
            if (i == 3) begin expect_v(P8, 16'h0008, 1'b0, "p8_up3"); expect_v(P16, 16'h0008, 1'b0, "p16_up3"); end
            if (i == 4) begin expect_v(P8, 16'h0011, 1'b0, "p8_up4"); expect_v(P16, 16'h0011, 1'b0, "p16_up4"); end
            tick();
        end
        for (int i = 1; i <= 100; i++) begin
            drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 99) begin
                expect_v(P8, 16'h0002, 1'b1, "p8_down_succ");
                expect_v(P16, 16'h0002, 1'b1, "p16_down_succ");
            end
            if (i == 100) begin
                expect_v(P8, 16'h0001, 1'b0, "p8_back_to_seed");
                expect_v(P16, 16'h0001, 1'b0, "p16_back_to_seed");
            end
            tick();
        end

        // rst mid-PR run wins over start
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) expect_v(w, 16'h0000, 1'b0, "rst_mid_run");
        tick();
        rst = 1'b0;

        // Linear window 2..5, out-of-window base 0 re-enters at MIN on an up step
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_v(LIN, 16'h0002, 1'b0, "lin_oow_up");
        tick();
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_v(LIN, 16'h0002, 1'b0, "lin_start");
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0003, 1'b0, "lin_up3"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0004, 1'b0, "lin_up4"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0005, 1'b1, "lin_up5_last"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0002, 1'b0, "lin_up_wrap"); tick();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b1); expect_v(LIN, 16'h0005, 1'b0, "lin_rev"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1); expect_v(LIN, 16'h0004, 1'b0, "lin_dn4"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1); expect_v(LIN, 16'h0003, 1'b0, "lin_dn3"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1); expect_v(LIN, 16'h0002, 1'b1, "lin_dn2_last"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1); expect_v(LIN, 16'h0005, 1'b0, "lin_dn_wrap"); tick();

        // Reserved mode 11 behaves as linear
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0002, 1'b0, "mode11_start"); tick();
        drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0003, 1'b0, "mode11_up"); tick();

        // Hold keeps address and flag, even across a mode/direction change
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            expect_v(LIN, 16'h0003, 1'b0, "hold_stable");
            tick();
        end
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0004, 1'b0, "after_hold"); tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); expect_v(LIN, 16'h0005, 1'b1, "pre_hold_last"); tick();
        for (int i = 0; i < 2; i++) begin
            drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
            expect_v(LIN, 16'h0005, 1'b1, "hold_keeps_last");
            tick();
        end

        // Priority: start over rev, rev over hold
        drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0); expect_v(LIN, 16'h0002, 1'b0, "start_over_rev"); tick();
        drive(2'b00, 1'b0, 1'b1, 1'b1, 1'b0); expect_v(LIN, 16'h0005, 1'b1, "rev_over_hold"); tick();

        // Complement mode on the full 4-bit window
        drive(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_v(P4, 16'h0000, 1'b0, "cpl_start");
        tick();
        for (int k = 1; k <= 32; k++) begin
            drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADDR_GEN_CPL_EN
            b  = 4'(k / 2);
            ph = (k % 2) == 1;
            expect_v(P4, {12'h000, (ph ? ~b : b)}, (ph && b == 4'hF), "cpl_seq");
`else
            b = 4'(k);
            expect_v(P4, {12'h000, b}, (b == 4'hF), "cpl_off_linear");
`endif
            tick();
        end

        tick();
        tick();
        if (sb_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/address_gen_param.md
# address_gen_param

Parametrised address generator for the PMBIST datapath, succeeding the fixed 8-bit address counter. Produces the test address sequence for any memory depth from 2^4 to 2^16 with a programmable linear window, a width-matched reversible LFSR and an optional address-complement mode. It also flags the terminal address of each march element. It sits between the BIST controller FSM (start/reverse/hold/direction) and the memory address port.

## Interface
- AW, 8: address width, legal 4..16
- ADDR_MIN, 0: lowest address, linear and complement modes
- ADDR_MAX, 2^AW-1: highest address, linear and complement modes; must be ≥ ADDR_MIN
- PR_SEED, 1: LFSR seed; a value of 0 is replaced by 1
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mode_in  in  2  00 linear, 01 pseudo-random, 10 complement, 11 reserved (acts as linear)
- start_in  in  1  load first address of an up sequence
- rev_in  in  1  load first address of a down sequence
- hold_in  in  1  freeze address
- updwn_in  in  1  0 up, 1 down
- tas_out  out  AW  test address
- last_out  out  1  tas_out is terminal address for current mode/direction

## Operation
- Priority, per clk edge: rst > start_in > rev_in > hold_in > step.
- Reset: base=0, phase=0, tas_out=0, last_out=0.
- Linear: start loads ADDR_MIN, rev loads ADDR_MAX. Up step +1, with ADDR_MAX → ADDR_MIN. Down step −1, with ADDR_MIN → ADDR_MAX. Out-of-window value on step: load ADDR_MIN (up) or ADDR_MAX (down).
- Pseudo-random: start and rev both load PR_SEED; the window is ignored; the sequence covers all 2^AW−1 nonzero values.
  - Taps (Fibonacci, bit t = c[t−1]) by AW: 4:4,3 / 5:5,3 / 6:6,5 / 7:7,6 / 8:8,6,5,4 / 9:9,5 / 10:10,7 / 11:11,9 / 12:12,6,4,1 / 13:13,4,3,1 / 14:14,5,3,1 / 15:15,14 / 16:16,15,13,4.
  - Up: c ← {c[AW−2:0], f}, where f = XOR of c[t−1] over all taps.
  - Down is the exact inverse: c[AW−2:0] ← c[AW−1:1]; c[AW−1] ← c[0] XOR (XOR of c[t] over taps t<AW).
  - Stepping from c=0 loads PR_SEED (lock-up escape).
- Complement: base follows linear rules. tas_out = phase ? ~base : base.
  - Step with phase=0 sets phase=1; base is unchanged.
  - Step with phase=1 clears phase and advances base one linear step.
  - start/rev clear phase.
- A mode_in or updwn_in change takes effect at the next step; the address is not reloaded.
- last_out terminal address:
  - linear up: ADDR_MAX; linear down: ADDR_MIN
  - PR up: predecessor of PR_SEED; PR down: successor of PR_SEED (elaboration constants)
  - complement: phase=1 and base at the linear terminal
- Hold keeps tas_out and last_out unchanged.

## Timing
- All outputs are registered. A control sampled at edge n is reflected on tas_out/last_out after edge n.
- last_out is computed from the next-state value and is therefore valid in the same cycle as the terminal tas_out.
- One address per cycle. There is no wait state at wrap.
- rst asserted mid-sequence: outputs reach reset values after that edge regardless of other inputs.

## Configuration
- ADDR_GEN_CPL_EN defined: complement mode is available.
- ADDR_GEN_CPL_EN undefined: no phase register is built, mode 10 behaves as linear, and last_out uses linear rules.

## Test plan
- Linear window (AW=4, MIN=2, MAX=5): start, then 4 up steps → 2,3,4,5,2; last_out is high only with 5. Rev plus down steps → 5,4,3,2,5.
- PR AW=4, seed 1: start plus up steps → 1,2,4,9,3,… Full cycle of 15 distinct nonzero values returns to 1; last_out is high on 8. Down from 1 → 8; down last_out is on 2.
- PR reversibility for AW=8 and AW=16: 100 up steps then 100 down steps return to PR_SEED; the zero-state escape loads the seed.
- Complement (AW=4, full window, macro on): start plus up steps → 0,F,1,E,2,D; at base F, phase 1, last_out=1. Macro off: same stimulus → 0,1,2,3.
- Priority and hold: start+rev together → ADDR_MIN. hold for 3 cycles → tas_out is stable. rst mid-PR-run → tas_out=0, last_out=0 on the next edge.
